if_fetch: RTL and testbench

Instruction-fetch stage that produces the PC/instruction pairs consumed by the IF/ID pipeline register. It owns the program counter, issues one-outstanding read requests to the instruction bus, buffers returned words in a 2-entry FIFO, and presents them downstream with a valid/stall handshake. Branch redirects flush the FIFO and discard any in-flight response.

---
 rtl/if_fetch.sv | 156 +++++++++++++++
 tb/tb_if_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one read outstanding on the
// instruction bus and buffers up to two {pc, inst} pairs for the decode stage.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] fetch_pc_r;
  logic [31:0] req_addr_r;
  logic [1:0]  count_r;
  logic [31:0] pc0_r, inst0_r, pc1_r, inst1_r;

  logic        pop_s;
  logic        push_s;
  logic        launch_s;
  logic [1:0]  count_next_s;
  logic [1:0]  widx_s;
  logic [31:0] pc0_next_s, inst0_next_s, pc1_next_s, inst1_next_s;

  // Handshake terms, occupancy and launch decision for this cycle.
  always_comb begin
    pop_s  = (count_r != 2'd0) & ~stall;
    push_s = ibus_ack & (state_r == S_WAIT) & ~branch_flag;
    if (branch_flag) begin
      count_next_s = 2'd0;
    end else begin
      count_next_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
    end
    // A new request may only go out once the current one has completed.
    launch_s = ~branch_flag & (count_next_s <= 2'd1) &
               ((state_r == S_IDLE) | ibus_ack);
  end

  // Next FIFO contents: the head always lives in entry 0, pop shifts entry 1 down.
  always_comb begin
    pc0_next_s   = pc0_r;
    inst0_next_s = inst0_r;
    pc1_next_s   = pc1_r;
    inst1_next_s = inst1_r;
    widx_s       = count_r - {1'b0, pop_s};
    if (pop_s) begin
      pc0_next_s   = pc1_r;
      inst0_next_s = inst1_r;
    end else begin
      pc0_next_s   = pc0_r;
      inst0_next_s = inst0_r;
    end
    if (push_s) begin
      if (widx_s == 2'd0) begin
        pc0_next_s   = req_addr_r;
        inst0_next_s = ibus_rdata;
      end else begin
        pc1_next_s   = req_addr_r;
        inst1_next_s = ibus_rdata;
      end
    end else begin
      pc1_next_s   = pc1_r;
      inst1_next_s = inst1_r;
    end
  end

  // Next bus-side state; a redirect turns an un-acked request into a discard.
  always_comb begin
    state_next_s = state_r;
    if (branch_flag) begin
      if ((state_r != S_IDLE) && !ibus_ack) begin
        state_next_s = S_DROP;
      end else begin
        state_next_s = S_IDLE;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          state_next_s = launch_s ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          if (ibus_ack) begin
            state_next_s = launch_s ? S_WAIT : S_IDLE;
          end else begin
            state_next_s = S_WAIT;
          end
        end
        S_DROP: begin
          if (ibus_ack) begin
            state_next_s = launch_s ? S_WAIT : S_IDLE;
          end else begin
            state_next_s = S_DROP;
          end
        end
        default: begin
          state_next_s = S_IDLE;
        end
      endcase
    end
  end

  // State, PC, FIFO and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      fetch_pc_r <= RESET_PC;
      req_addr_r <= 32'h0000_0000;
      count_r    <= 2'd0;
      pc0_r      <= 32'h0000_0000;
      inst0_r    <= 32'h0000_0000;
      pc1_r      <= 32'h0000_0000;
      inst1_r    <= 32'h0000_0000;
      ibus_req   <= 1'b0;
      ibus_addr  <= 32'h0000_0000;
      if_valid   <= 1'b0;
      if_pc      <= 32'h0000_0000;
      if_inst    <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      pc0_r   <= pc0_next_s;
      inst0_r <= inst0_next_s;
      pc1_r   <= pc1_next_s;
      inst1_r <= inst1_next_s;
      if (branch_flag) begin
        fetch_pc_r <= branch_target & 32'hFFFF_FFFC;
      end else if (launch_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      if (launch_s) begin
        req_addr_r <= fetch_pc_r;
        ibus_addr  <= fetch_pc_r;
      end
      ibus_req <= (state_next_s != S_IDLE);
      if_valid <= (count_next_s != 2'd0);
      if_pc    <= (count_next_s != 2'd0) ? pc0_next_s   : 32'h0000_0000;
      if_inst  <= (count_next_s != 2'd0) ? inst0_next_s : 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: a queue-based fetch model predicts the bus
// request and the presented PC/instruction every cycle.
module tb_if_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .ibus_req      (ibus_req),
    .ibus_addr     (ibus_addr),
    .ibus_ack      (ibus_ack),
    .ibus_rdata    (ibus_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pair_t;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  pair_t       mq[$];
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_fetch;
  logic [31:0] m_raddr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: an outstanding-read flag, a discard flag and a queue of words.
  task automatic model_step();
    bit ack_eff;
    ack_eff = ibus_ack && m_out;
    if (rst) begin
      mq.delete();
      m_out   = 1'b0;
      m_drop  = 1'b0;
      m_fetch = RPC;
      m_raddr = 32'h0000_0000;
    end else if (branch_flag) begin
      mq.delete();
      if (m_out && !ibus_ack) begin
        m_drop = 1'b1;
      end else begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      m_fetch = branch_target & 32'hFFFF_FFFC;
    end else begin
      if (mq.size() > 0 && !stall) void'(mq.pop_front());
      if (ack_eff && !m_drop) mq.push_back({m_raddr, ibus_rdata});
      if (ack_eff) begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      if (!m_out && mq.size() <= 1) begin
        m_out   = 1'b1;
        m_raddr = m_fetch;
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  task automatic compare_outs();
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    exp_pc   = (mq.size() > 0) ? mq[0].pc   : 32'h0000_0000;
    exp_inst = (mq.size() > 0) ? mq[0].inst : 32'h0000_0000;
    check_val("ibus_req",  {31'd0, ibus_req}, {31'd0, m_out});
    check_val("ibus_addr", ibus_addr, m_raddr);
    check_val("if_valid",  {31'd0, if_valid}, {31'd0, (mq.size() > 0)});
    check_val("if_pc",     if_pc, exp_pc);
    check_val("if_inst",   if_inst, exp_inst);
  endtask

  task automatic cyc(input logic r, input logic s, input logic a, input logic b,
                     input logic [31:0] t);
    rst           = r;
    stall         = s;
    ibus_ack      = a;
    branch_flag   = b;
    branch_target = t;
    ibus_rdata    = $urandom;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outs();
  endtask

  initial begin
    // Reset, then zero-wait streaming from RESET_PC.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, m_out, 1'b0, 32'd0);

    // Stall held while streaming, then released.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, m_out, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, m_out, 1'b0, 32'd0);

    // Slow bus: three wait cycles per access.
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 3; w++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    end

    // Redirect while the read to 0x10C is still waiting.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 20 && !(m_out && m_raddr == 32'h0000_010C); i++)
      cyc(1'b0, 1'b0, m_out, 1'b0, 32'd0);
    check_val("reach_10c", m_raddr, 32'h0000_010C);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2002);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2002);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, m_out, 1'b0, 32'd0);

    // Redirect coincident with an ack.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2002);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, m_out, 1'b0, 32'd0);

    // Reset with a full FIFO under stall, then a stray ack just after reset.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, m_out, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, m_out, 1'b0, 32'd0);

    // PC wrap past 0xFFFF_FFFC.
    cyc(1'b0, 1'b0, m_out, 1'b1, 32'hFFFF_FFF5);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, m_out, 1'b0, 32'd0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic        r, s, a, b;
      logic [31:0] t;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 9) < 3);
      a = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      b = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      cyc(r, s, a, b, t);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
